pc_seq_ctrl: RTL and testbench

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pc_seq_ctrl
//
// Program-counter sequencer. A three-state FSM (BOOT -> FETCH -> EXEC) issues
// one instruction fetch at a time. The PC is held while a fetch is
// outstanding and while EXEC is stalled. It advances only on the EXEC cycle
// in which stall is low. That update picks jump_target, branch_target or
// pc + 4, in that order of priority.
//
// Optional feature (macro PC_ALIGN_CHECK_EN):
//   defined   - a jump/branch target with bits [1:0] != 0 loads TRAP_VECTOR
//               and raises a one-cycle misalign pulse on the following cycle.
//   undefined - no misalign port; the low two bits of a loaded target are
//               cleared so the PC always stays word aligned.
//
// Parameters
//   instruction_width : width of PC, targets and fetch address
//   RESET_VECTOR      : PC value after reset
//   TRAP_VECTOR       : PC value loaded on a misaligned target
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   stall          in   hold current instruction and PC in EXEC
//   jump           in   select jump_target (highest priority)
//   jump_target    in   jump destination
//   branch_taken   in   select branch_target
//   branch_target  in   branch destination
//   imem_ack       in   instruction word returned (honoured in FETCH only)
//   imem_req       out  fetch request, high only in FETCH
//   imem_addr      out  fetch address (= pc_addr)
//   pc_addr        out  current PC register
//   pc_next        out  pc_addr + 4, wraps modulo 2^instruction_width
//   instr_valid    out  high in every EXEC cycle
//   misalign       out  misaligned-target pulse (PC_ALIGN_CHECK_EN only)
// ---------------------------------------------------------------------------
module pc_seq_ctrl #(
    parameter int                           instruction_width = 32,
    parameter logic [instruction_width-1:0] RESET_VECTOR      = 32'h0000_0000,
    parameter logic [instruction_width-1:0] TRAP_VECTOR       = 32'h0000_0080
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         jump,
    input  logic [instruction_width-1:0] jump_target,
    input  logic                         branch_taken,
    input  logic [instruction_width-1:0] branch_target,
    input  logic                         imem_ack,
    output logic                         imem_req,
    output logic [instruction_width-1:0] imem_addr,
    output logic [instruction_width-1:0] pc_addr,
    output logic [instruction_width-1:0] pc_next,
    output logic                         instr_valid
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                         misalign
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [instruction_width-1:0] PC_STEP  =
        {{(instruction_width-3){1'b0}}, 3'b100};
    localparam logic [instruction_width-1:0] WORD_MSK =
        {{(instruction_width-2){1'b1}}, 2'b00};

    state_t                         r_state;
    state_t                         w_state_next;
    logic [instruction_width-1:0]   r_pc;
    logic [instruction_width-1:0]   w_pc_inc;
    logic [instruction_width-1:0]   w_sel_target;
    logic [instruction_width-1:0]   w_pc_load;
    logic                           w_take;
    logic                           w_advance;

    // Plain binary add: carry out of the top bit is dropped, giving the
    // modulo wrap from the last word back to address zero.
    assign w_pc_inc     = r_pc + PC_STEP;

    // The PC only moves on the EXEC cycle that completes (stall low). All
    // redirect inputs are don't-care at any other time.
    assign w_advance    = (r_state == EXEC) && !stall;
    assign w_take       = jump || branch_taken;
    assign w_sel_target = jump ? jump_target : branch_target;

`ifdef PC_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_misalign;

    assign w_misaligned = w_take && (w_sel_target[1:0] != 2'b00);
    assign w_pc_load    = w_misaligned ? TRAP_VECTOR  :
                          w_take       ? w_sel_target :
                                         w_pc_inc;

    // Registered so the pulse appears in the cycle after the offending EXEC
    // and lasts exactly one cycle (w_advance cannot be high twice in a row,
    // since EXEC is always followed by FETCH when it completes).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_advance && w_misaligned;
        end
    end

    assign misalign = r_misalign;
`else
    // Without the check, the target is silently rounded down to a word.
    assign w_pc_load = w_take ? (w_sel_target & WORD_MSK) : w_pc_inc;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. imem_ack is only looked at in FETCH, so a late ack
    // that lands in BOOT or EXEC has no effect.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = FETCH;
            FETCH:   w_state_next = imem_ack ? EXEC : FETCH;
            EXEC:    w_state_next = stall ? EXEC : FETCH;
            default: w_state_next = BOOT;
        endcase
    end

    // PC register: unchanged through FETCH, so the request address is stable
    // until the ack is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VECTOR;
        end else if (w_advance) begin
            r_pc <= w_pc_load;
        end
    end

    // Outputs are decoded straight from the state register. BOOT is the
    // reset state, so imem_req and instr_valid read 0 throughout reset.
    assign imem_req    = (r_state == FETCH);
    assign instr_valid = (r_state == EXEC);
    assign pc_addr     = r_pc;
    assign imem_addr   = r_pc;
    assign pc_next     = w_pc_inc;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_seq_ctrl
//
// Directed bench for pc_seq_ctrl. The stimulus process pushes each expected
// fetch address into a queue. A monitor pops the queue whenever the DUT
// completes a fetch handshake (imem_req && imem_ack) and compares the popped
// value with imem_addr. Cycle-exact properties are checked inline:
//   - reset values
//   - wait-state stability
//   - stall hold
//   - instr_valid width
//   - misalign pulse
// ---------------------------------------------------------------------------
module tb_pc_seq_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         jump;
    logic [W-1:0] jump_target;
    logic         branch_taken;
    logic [W-1:0] branch_target;
    logic         imem_ack;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic [W-1:0] pc_addr;
    logic [W-1:0] pc_next;
    logic         instr_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic         misalign;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    pc_seq_ctrl #(
        .instruction_width (W),
        .RESET_VECTOR      (32'h0000_0000),
        .TRAP_VECTOR       (32'h0000_0080)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc_addr       (pc_addr),
        .pc_next       (pc_next),
        .instr_valid   (instr_valid)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign      (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end else begin
            $display("ok   %s value=0x%08h", name, act);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Outputs are then
    // stable for the rest of the cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one comparison per completed fetch handshake.
    always @(negedge clk) begin
        if (imem_req && imem_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fetch_unexpected actual=0x%08h expected=none", imem_addr);
            end else begin
                check("fetch_addr", imem_addr, exp_q.pop_front());
            end
        end
    end

    localparam logic [W-1:0] EXP_MIS =
`ifdef PC_ALIGN_CHECK_EN
        32'h0000_0080;
`else
        32'h0000_0100;
`endif

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        jump = 1'b0;
        jump_target = '0;
        branch_taken = 1'b0;
        branch_target = '0;
        imem_ack = 1'b1;

        // ---- reset test: 3 cycles of reset, ack tied high ----
        tick(); tick(); tick();
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc_addr, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
        check("rst_misalign", {31'd0, misalign}, 32'd0);
`endif
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        rst = 1'b0;
        // First cycle after release is still BOOT.
        check("boot_no_req", {31'd0, imem_req}, 32'd0);
        tick();                                  // FETCH 0x0
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        tick();                                  // EXEC 0x0
        check("exec_valid", {31'd0, instr_valid}, 32'd1);
        tick();                                  // FETCH 0x4
        check("second_addr", imem_addr, 32'h4);
        tick();                                  // EXEC 0x4
        tick();                                  // FETCH 0x8
        tick();                                  // EXEC 0x8
        imem_ack = 1'b0;

        // ---- wait-state test: ack withheld for 4 cycles ----
        tick();                                  // FETCH 0xC
        for (int i = 0; i < 4; i++) begin
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'hC);
            check("wait_no_valid", {31'd0, instr_valid}, 32'd0);
            tick();
        end
        exp_q.push_back(32'hC);
        imem_ack = 1'b1;
        tick();                                  // EXEC 0xC
        imem_ack = 1'b0;
        check("ack_valid_on", {31'd0, instr_valid}, 32'd1);
        tick();                                  // FETCH 0x10
        check("ack_valid_off", {31'd0, instr_valid}, 32'd0);
        check("fetch_0x10", imem_addr, 32'h10);

        // ---- priority test: jump beats branch ----
        exp_q.push_back(32'h10);
        imem_ack = 1'b1;
        tick();                                  // EXEC 0x10
        jump = 1'b1;
        jump_target = 32'h200;
        branch_taken = 1'b1;
        branch_target = 32'h100;
        exp_q.push_back(32'h200);
        tick();                                  // FETCH 0x200
        check("prio_pc", pc_addr, 32'h200);
        jump = 1'b0;
        branch_taken = 1'b0;
        tick();                                  // EXEC 0x200

        // ---- stall test: branch held off for 3 stalled EXEC cycles ----
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h300;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_pc", pc_addr, 32'h200);
            tick();
        end
        check("stall_end_pc", pc_addr, 32'h200);
        check("stall_end_valid", {31'd0, instr_valid}, 32'd1);
        stall = 1'b0;
        exp_q.push_back(32'h300);
        tick();                                  // FETCH 0x300
        check("branch_pc", pc_addr, 32'h300);
        branch_taken = 1'b0;
        tick();                                  // EXEC 0x300

        // ---- misalignment test: jump to 0x102 ----
        jump = 1'b1;
        jump_target = 32'h102;
        exp_q.push_back(EXP_MIS);
        tick();                                  // FETCH trap/aligned
        check("misalign_pc", pc_addr, EXP_MIS);
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_pulse", {31'd0, misalign}, 32'd1);
`endif
        jump = 1'b0;
        tick();                                  // EXEC
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_once", {31'd0, misalign}, 32'd0);
`endif

        // ---- wrap test: PC 0xFFFF_FFFC advances to 0 ----
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();                                  // FETCH 0xFFFFFFFC
        // A jump presented in FETCH must be ignored.
        jump_target = 32'h500;
        tick();                                  // EXEC 0xFFFFFFFC
        check("ignore_jump_fetch", pc_addr, 32'hFFFF_FFFC);
        check("wrap_pc_next", pc_next, 32'h0);
        jump = 1'b0;
        imem_ack = 1'b0;
        tick();                                  // FETCH 0x0, no ack
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc_next_4", pc_next, 32'h4);

        // ---- reset during FETCH, then a late ack in BOOT ----
        rst = 1'b1;
        tick();
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_pc", pc_addr, 32'h0);
        rst = 1'b0;
        imem_ack = 1'b1;                         // late ack, lands in BOOT
        exp_q.push_back(32'h0);
        tick();                                  // FETCH (not EXEC)
        check("late_ack_ignored_valid", {31'd0, instr_valid}, 32'd0);
        check("late_ack_req", {31'd0, imem_req}, 32'd1);
        tick();                                  // EXEC 0x0
        imem_ack = 1'b0;
        tick();
        tick();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
